ladder_ctrl: RTL and testbench



---
 rtl/ladder_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ladder_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ladder_ctrl.sv
// Montgomery-ladder sequencer for GF(2^233) LD-projective scalar multiply.
// Optional LADDER_SKIP_LZ_EN: skip leading zero key bits (not constant-time).
module ladder_ctrl #(
  parameter int N   = 233,
  parameter int K_W = 233
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START,
  input  logic [K_W-1:0] DIN_K,
  input  logic [N-1:0]   DIN_X,
  output logic           BUSY,
  output logic           DONE,
  output logic [N-1:0]   DOUT_X1,
  output logic [N-1:0]   DOUT_Z1,
  output logic [N-1:0]   DOUT_X2,
  output logic [N-1:0]   DOUT_Z2,
  output logic           AD_IN_VALID,
  output logic [N-1:0]   AD_P1_X,
  output logic [N-1:0]   AD_P1_Z,
  output logic [N-1:0]   AD_P2_X,
  output logic [N-1:0]   AD_P2_Z,
  output logic [N-1:0]   AD_P_x,
  input  logic           AD_OUT_VALID,
  input  logic [N-1:0]   AD_A_X,
  input  logic [N-1:0]   AD_A_Z,
  input  logic [N-1:0]   AD_D_X,
  input  logic [N-1:0]   AD_D_Z
);

  localparam int IW = (K_W > 1) ? $clog2(K_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_FINISH,
    S_SCAN
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [K_W-1:0] k_q;
  logic [N-1:0]   x_q;
  logic [N-1:0]   p1x_q;
  logic [N-1:0]   p1z_q;
  logic [N-1:0]   p2x_q;
  logic [N-1:0]   p2z_q;
  logic [IW-1:0]  i_q;
  logic           bit_b;
  logic           last;

  assign bit_b = k_q[i_q];
  assign last  = (i_q == '0);

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (START) state_d = S_LOAD;
`ifdef LADDER_SKIP_LZ_EN
      S_LOAD:   state_d = S_SCAN;
`else
      S_LOAD:   state_d = S_ISSUE;
`endif
      S_SCAN: begin
        if (bit_b)     state_d = S_ISSUE;
        else if (last) state_d = S_FINISH;
      end
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT: begin
        if (AD_OUT_VALID) state_d = last ? S_FINISH : S_DRAIN;
      end
      S_DRAIN:  if (!AD_OUT_VALID) state_d = S_ISSUE;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Ladder registers and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      k_q         <= '0;
      x_q         <= '0;
      p1x_q       <= '0;
      p1z_q       <= '0;
      p2x_q       <= '0;
      p2z_q       <= '0;
      i_q         <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      AD_IN_VALID <= 1'b0;
      AD_P1_X     <= '0;
      AD_P1_Z     <= '0;
      AD_P2_X     <= '0;
      AD_P2_Z     <= '0;
      AD_P_x      <= '0;
      DOUT_X1     <= '0;
      DOUT_Z1     <= '0;
      DOUT_X2     <= '0;
      DOUT_Z2     <= '0;
    end else begin
      AD_IN_VALID <= 1'b0;
      DONE        <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            k_q  <= DIN_K;
            x_q  <= DIN_X;
            BUSY <= 1'b1;
          end
        end
        S_LOAD: begin
          p1x_q  <= N'(1);
          p1z_q  <= '0;
          p2x_q  <= x_q;
          p2z_q  <= N'(1);
          i_q    <= IW'(K_W - 1);
          AD_P_x <= x_q;
        end
        S_SCAN: begin
          if (!bit_b && !last) i_q <= i_q - IW'(1);
        end
        S_ISSUE: begin
          AD_IN_VALID <= 1'b1;
          if (bit_b) begin
            AD_P1_X <= p1x_q;
            AD_P1_Z <= p1z_q;
            AD_P2_X <= p2x_q;
            AD_P2_Z <= p2z_q;
          end else begin
            AD_P1_X <= p2x_q;
            AD_P1_Z <= p2z_q;
            AD_P2_X <= p1x_q;
            AD_P2_Z <= p1z_q;
          end
        end
        S_WAIT: begin
          if (AD_OUT_VALID) begin
            if (bit_b) begin
              p1x_q <= AD_A_X;
              p1z_q <= AD_A_Z;
              p2x_q <= AD_D_X;
              p2z_q <= AD_D_Z;
            end else begin
              p2x_q <= AD_A_X;
              p2z_q <= AD_A_Z;
              p1x_q <= AD_D_X;
              p1z_q <= AD_D_Z;
            end
            if (!last) i_q <= i_q - IW'(1);
          end
        end
        S_FINISH: begin
          DOUT_X1 <= p1x_q;
          DOUT_Z1 <= p1z_q;
          DOUT_X2 <= p2x_q;
          DOUT_Z2 <= p2z_q;
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ladder_ctrl.sv
// Bench for ladder_ctrl: add/double stub tracks points as integer
// multiples of x, so k*P shows up as X1 = k*x, X2 = (k+1)*x.
module tb_ladder_ctrl;

  localparam int N   = 233;
  localparam int K_W = 233;
  localparam logic [N-1:0] KM  = {1'b1, 224'h0, 8'hA5};
  localparam logic [N-1:0] KM1 = {1'b1, 224'h0, 8'hA6};

  logic           CLK = 1'b0;
  logic           RST_N;
  logic           START;
  logic [K_W-1:0] DIN_K;
  logic [N-1:0]   DIN_X;
  logic           BUSY;
  logic           DONE;
  logic [N-1:0]   DOUT_X1, DOUT_Z1, DOUT_X2, DOUT_Z2;
  logic           AD_IN_VALID;
  logic [N-1:0]   AD_P1_X, AD_P1_Z, AD_P2_X, AD_P2_Z, AD_P_x;
  logic           AD_OUT_VALID;
  logic [N-1:0]   AD_A_X, AD_A_Z, AD_D_X, AD_D_Z;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int done_cnt = 0;
  int bad_inv = 0;
  int hold = 1;
  int lat = 2;
  int scnt = 0;
  logic [N-1:0] f1x, f1z, f2x, f2z;

  ladder_ctrl #(.N(N), .K_W(K_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .DIN_K(DIN_K), .DIN_X(DIN_X),
    .BUSY(BUSY), .DONE(DONE),
    .DOUT_X1(DOUT_X1), .DOUT_Z1(DOUT_Z1),
    .DOUT_X2(DOUT_X2), .DOUT_Z2(DOUT_Z2),
    .AD_IN_VALID(AD_IN_VALID),
    .AD_P1_X(AD_P1_X), .AD_P1_Z(AD_P1_Z),
    .AD_P2_X(AD_P2_X), .AD_P2_Z(AD_P2_Z),
    .AD_P_x(AD_P_x), .AD_OUT_VALID(AD_OUT_VALID),
    .AD_A_X(AD_A_X), .AD_A_Z(AD_A_Z),
    .AD_D_X(AD_D_X), .AD_D_Z(AD_D_Z)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] dec(input logic [N-1:0] x,
                                       input logic [N-1:0] z);
    return (z == '0) ? '0 : x;
  endfunction

  function automatic logic [2*N-1:0] enc(input logic [N-1:0] m);
    return (m == '0) ? {N'(1), N'(0)} : {m, N'(1)};
  endfunction

  // add/double stub: latency lat, result valid held for hold cycles
  initial begin
    logic [N-1:0] m1, m2;
    AD_OUT_VALID = 1'b0;
    AD_A_X = '0; AD_A_Z = '0; AD_D_X = '0; AD_D_Z = '0;
    forever begin
      @(negedge CLK);
      if (scnt > 0) begin
        scnt--;
        AD_OUT_VALID = (scnt < hold);
      end else begin
        AD_OUT_VALID = 1'b0;
      end
      if (AD_IN_VALID) begin
        m1 = dec(AD_P1_X, AD_P1_Z);
        m2 = dec(AD_P2_X, AD_P2_Z);
        if ((m2 - m1) != AD_P_x && (m1 - m2) != AD_P_x) bad_inv++;
        if (pulses == 0) begin
          f1x = AD_P1_X; f1z = AD_P1_Z;
          f2x = AD_P2_X; f2z = AD_P2_Z;
        end
        {AD_A_X, AD_A_Z} = enc(m1 + m2);
        {AD_D_X, AD_D_Z} = enc(m2 << 1);
        pulses++;
        scnt = lat + hold;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (DONE) done_cnt++;
    end
  end

  task automatic run(input string tag, input logic [K_W-1:0] k,
                     input logic [N-1:0] x, input int rs_at,
                     input int exp_p);
    logic got;
    bit rs_done;
    got = 1'b0;
    rs_done = 1'b0;
    pulses = 0;
    done_cnt = 0;
    bad_inv = 0;
    DIN_K = k;
    DIN_X = x;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge CLK);
      START = 1'b0;
      if (rs_at >= 0 && !rs_done && pulses == rs_at) begin
        START = 1'b1;
        DIN_K = '0;
        DIN_X = N'(7);
        rs_done = 1'b1;
      end
      if (DONE) begin
        got = 1'b1;
        break;
      end
    end
    START = 1'b0;
    chk({tag, "_done"}, N'(got), N'(1));
    repeat (4) @(negedge CLK);
    chk({tag, "_pulses"}, N'(pulses), N'(exp_p));
    chk({tag, "_ndone"}, N'(done_cnt), N'(1));
    chk({tag, "_inv"}, N'(bad_inv), N'(0));
    chk({tag, "_busy"}, N'(BUSY), N'(0));
    chk({tag, "_px"}, AD_P_x, x);
  endtask

  task automatic res(input string tag, input logic [N-1:0] x1,
                     input logic [N-1:0] z1, input logic [N-1:0] x2,
                     input logic [N-1:0] z2);
    chk({tag, "_x1"}, DOUT_X1, x1);
    chk({tag, "_z1"}, DOUT_Z1, z1);
    chk({tag, "_x2"}, DOUT_X2, x2);
    chk({tag, "_z2"}, DOUT_Z2, z2);
  endtask

  initial begin
    bit hit;
    RST_N = 1'b0;
    START = 1'b0;
    DIN_K = '0;
    DIN_X = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", N'(BUSY), N'(0));
    chk("rst_done", N'(DONE), N'(0));
    chk("rst_aiv", N'(AD_IN_VALID), N'(0));
    chk("rst_x1", DOUT_X1, '0);
    chk("rst_px", AD_P_x, '0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

`ifdef LADDER_SKIP_LZ_EN
    run("k1", K_W'(1), N'(1), -1, 1);
`else
    run("k1", K_W'(1), N'(1), -1, K_W);
`endif
    res("k1", N'(1), N'(1), N'(2), N'(1));

`ifdef LADDER_SKIP_LZ_EN
    run("k0", '0, N'('hABC), -1, 0);
`else
    run("k0", '0, N'('hABC), -1, K_W);
`endif
    res("k0", N'(1), N'(0), N'('hABC), N'(1));

    hold = 4;
    run("kmsb", KM, N'(1), -1, K_W);
    res("kmsb", KM, N'(1), KM1, N'(1));
    chk("kmsb_f1x", f1x, N'(1));
    chk("kmsb_f1z", f1z, N'(0));
    chk("kmsb_f2x", f2x, N'(1));
    chk("kmsb_f2z", f2z, N'(1));

    run("rs", KM, N'(1), 50, K_W);
    res("rs", KM, N'(1), KM1, N'(1));
    hold = 1;

`ifdef LADDER_SKIP_LZ_EN
    run("k5", K_W'(5), N'(3), -1, 3);
    chk("k5_f1x", f1x, N'(1));
    chk("k5_f1z", f1z, N'(0));
    chk("k5_f2x", f2x, N'(3));
    chk("k5_f2z", f2z, N'(1));
`else
    run("k5", K_W'(5), N'(3), -1, K_W);
    chk("k5_f1x", f1x, N'(3));
    chk("k5_f1z", f1z, N'(1));
    chk("k5_f2x", f2x, N'(1));
    chk("k5_f2z", f2z, N'(0));
`endif
    res("k5", N'('hF), N'(1), N'('h12), N'(1));

    pulses = 0;
    done_cnt = 0;
    hit = 1'b0;
    DIN_K = KM;
    DIN_X = N'(1);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge CLK);
      if (pulses == 100) begin
        hit = 1'b1;
        break;
      end
    end
    chk("ab_reach", N'(hit), N'(1));
    RST_N = 1'b0;
    @(negedge CLK);
    chk("ab_busy", N'(BUSY), N'(0));
    chk("ab_aiv", N'(AD_IN_VALID), N'(0));
    chk("ab_x1", DOUT_X1, '0);
    RST_N = 1'b1;
    repeat (40) @(negedge CLK);
    chk("ab_ndone", N'(done_cnt), N'(0));
    chk("ab_idle", N'(BUSY), N'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
